eth_tx_frame_sequencer: RTL and testbench
=========================================

Name: eth_tx_frame_sequencer

Overview:
Frame-level controller directly upstream of the 10BASE-T Manchester transmitter in the cheap Ethernet TX path.
- Accepts a send request for a frame already held in packet RAM (preamble + SFD + header + payload).
- Drives SendingPacket for the exact frame duration.
- Computes the IEEE 802.3 CRC-32 bit-serially from the transmitter's shift register.
- Drives CRCflush/CRC so the transmitter appends the 4-byte FCS.
- Enforces the inter-packet gap before accepting the next request.

Parameters:
PREAMBLE_BYTES, 8, RAM bytes before the CRC-covered region (7x 0x55 + SFD 0xD5).
IPG_CLKS, 192, minimum idle clocks after SendingPacket falls (9.6 us at 20 MHz).
LEN_W, 11, width of byte length and RAM address.

Ports:
clk20  in  1  20 MHz clock.
rst  in  1  reset, asynchronous, active-high.
start  in  1  single-cycle send request; ignored unless ready=1.
pkt_len  in  LEN_W  total RAM bytes including preamble/SFD, excluding FCS; sampled when start is accepted.
ShiftCount  in  4  transmitter bit-phase counter (free-runs 0..15 while sending, held at 15 otherwise).
ShiftData0  in  1  transmitter ShiftData[0], the current data bit.
rdaddress  in  LEN_W  transmitter RAM read address (next byte to load on ShiftCount==15).
SendingPacket  out  1  frame active.
CRCflush  out  1  FCS bits are being transmitted.
CRC  out  1  current FCS bit, equal to ~crc_q[31].
ready  out  1  idle and gap elapsed; start will be accepted.
done  out  1  one-cycle pulse when SendingPacket falls.

Behaviour:
- Reset values: SendingPacket=0, CRCflush=0, CRC=0 (crc_q=all ones), ready=1, done=0, state=IDLE, len_q=0, gap counter=0.
- Asynchronous reset aborts any frame mid-operation. SendingPacket drops immediately; the transmitter returns rdaddress to 0 on its own.
- FSM states: IDLE, DATA, FCS, GAP.
- IDLE: ready=1. A start pulse latches len_q<=pkt_len, sets SendingPacket=1 at the next edge, and moves to DATA.
  - start with pkt_len < PREAMBLE_BYTES+1 is ignored; ready stays 1.
- DATA: on the edge where ShiftCount==15 and rdaddress==len_q, set CRCflush<=1 and move to FCS. The last RAM byte is then on the wire.
- FCS: lasts exactly 4 byte slots (64 clocks). On the edge where ShiftCount==14 and rdaddress==len_q+4:
  - SendingPacket<=0 and CRCflush<=0 (the final half-bit completes);
  - done pulses for 1 cycle;
  - move to GAP.
- GAP: count IPG_CLKS clocks, then go to IDLE.
  - ready=0 throughout GAP; start is ignored in DATA, FCS and GAP.
- CRC register crc_q (32 bits) updates only on clocks where SendingPacket=1 and ShiftCount[0]==1. One update per wire bit, LSB-first. Priority:
  1. rdaddress <= PREAMBLE_BYTES (byte on wire is preamble/SFD): crc_q <= 32'hFFFFFFFF.
  2. CRCflush=1: crc_q <= {crc_q[30:0],1'b1}, shifting out the complemented remainder.
  3. Otherwise: fb = ShiftData0 ^ crc_q[31]; crc_q <= {crc_q[30:0],1'b0} ^ ({32{fb}} & 32'h04C11DB7).
- CRC output is combinational ~crc_q[31]; the transmitter muxes it only while CRCflush=1.
- rdaddress comparisons use LEN_W+1 bits so len_q+4 does not wrap.
- A frame needing rdaddress beyond 2^LEN_W-1 is outside the contract.
- Simultaneous start and rst: rst wins.

Decomposition:
- Package eth_tx_pkg holds:
  - CRC32_POLY=32'h04C11DB7, CRC32_INIT=32'hFFFFFFFF, CRC32_RESIDUE=32'hC704DD7B;
  - state enum {IDLE,DATA,FCS,GAP};
  - PREAMBLE_BYTES default.
- One sub-module, eth_crc32_serial: bit-serial CRC register with ports init, flush, en, din and output crc_bit. It is reusable by the future RX checker.

Test Plan:
- Known-answer FCS: RAM = 55x7, D5, ASCII "123456789"; pkt_len=17. Frame must carry FCS bytes 26 39 F4 CB, LSB-first per byte. SendingPacket must be high exactly (17+4)*16 clocks, minus the documented half-bit alignment.
- Minimum Ethernet frame: 8+60 bytes, random payload. Decoded FCS must match a reference model. A receiver-side CRC over data+FCS must equal residue C704DD7B.
- Back-to-back: assert start every cycle. The second frame's SendingPacket must rise no earlier than 192 clocks after the first falls. ready must read 0 in GAP and 1 after.
- Ignored requests: start while in DATA, and start with pkt_len=8, must both be ignored. No SendingPacket change occurs and done is not pulsed.
- Reset mid-FCS: assert rst during the 2nd FCS byte. SendingPacket, CRCflush and CRC must go to 0 immediately and ready to 1. A following frame must produce a correct FCS.
- CRC gating: hold ShiftCount=15 in idle. crc_q must stay at all ones and CRCflush at 0 across 1000 clocks.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg
// Shared constants and types for the 10BASE-T transmit frame path:
// CRC-32 polynomial / init / receive residue, sequencer state encoding,
// and the default count of uncovered preamble+SFD bytes.
package eth_tx_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  localparam int unsigned PREAMBLE_BYTES_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    FCS  = 2'd2,
    GAP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/eth_crc32_serial.sv
// eth_crc32_serial
// Bit-serial IEEE 802.3 CRC-32 register, one data bit per enabled clock,
// data presented LSB-first. While flushing, the register shifts in ones so
// that crc_bit walks out the complemented remainder, MSB of the register
// first (which is FCS bit 0 on the wire).
// Ports:
//   clk     - clock
//   rst     - asynchronous active-high reset (register to all ones)
//   init    - reload all ones on the next enabled clock (highest priority)
//   flush   - shift out the remainder instead of absorbing din
//   en      - advance one bit
//   din     - current data bit
//   crc_bit - current FCS bit, ~r_crc[31]
module eth_crc32_serial
  import eth_tx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic flush,
  input  logic en,
  input  logic din,
  output logic crc_bit
);

  logic [31:0] r_crc;
  logic        w_fb;

  assign w_fb = din ^ r_crc[31];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc <= CRC32_INIT;
    end else if (en) begin
      if (init) begin
        r_crc <= CRC32_INIT;
      end else if (flush) begin
        r_crc <= {r_crc[30:0], 1'b1};
      end else begin
        r_crc <= {r_crc[30:0], 1'b0} ^ ({32{w_fb}} & CRC32_POLY);
      end
    end
  end

  assign crc_bit = ~r_crc[31];

endmodule

// File: rtl/eth_tx_frame_sequencer.sv
// eth_tx_frame_sequencer
// Frame-level controller in front of the Manchester transmitter. Accepts a
// send request for a frame in packet RAM, holds SendingPacket for the frame
// plus 4 FCS bytes, computes the CRC-32 from the transmitter's bit stream,
// and enforces the inter-packet gap before accepting another request.
// Ports:
//   clk20, rst          - 20 MHz clock, async active-high reset
//   start, pkt_len      - send request and total RAM bytes (preamble..payload)
//   ShiftCount          - transmitter bit phase (held at 15 when idle)
//   ShiftData0          - current transmitter data bit
//   rdaddress           - transmitter RAM address of the next byte to load
//   SendingPacket       - frame active
//   CRCflush, CRC       - FCS bits in flight / current FCS bit
//   ready, done         - request accepted next cycle / frame-end pulse
//
// state | meaning
// IDLE  | waiting for start; ready=1
// DATA  | RAM bytes on the wire
// FCS   | 4 FCS bytes on the wire, CRCflush=1
// GAP   | inter-packet gap countdown
module eth_tx_frame_sequencer
  import eth_tx_pkg::*;
#(
  parameter int unsigned PREAMBLE_BYTES = PREAMBLE_BYTES_DEFAULT,
  parameter int unsigned IPG_CLKS       = 192,
  parameter int unsigned LEN_W          = 11
) (
  input  logic             clk20,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic [3:0]       ShiftCount,
  input  logic             ShiftData0,
  input  logic [LEN_W-1:0] rdaddress,
  output logic             SendingPacket,
  output logic             CRCflush,
  output logic             CRC,
  output logic             ready,
  output logic             done
);

  localparam int unsigned LW1   = LEN_W + 1;
  localparam int unsigned GAP_W = $clog2(IPG_CLKS + 1);

  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(IPG_CLKS - 1);
  localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
  localparam logic [LW1-1:0]   MIN_LEN   = LW1'(PREAMBLE_BYTES + 1);
  localparam logic [LW1-1:0]   PRE_LAST  = LW1'(PREAMBLE_BYTES);
  localparam logic [LW1-1:0]   FCS_BYTES = LW1'(4);

  tx_state_t        r_state, w_state_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic [GAP_W-1:0] r_gap, w_gap_nxt;
  logic             r_sending, w_sending_nxt;
  logic             r_flush, w_flush_nxt;
  logic             r_done, w_done_nxt;

  logic [LW1-1:0]   w_rdaddr;
  logic [LW1-1:0]   w_len_ext;
  logic             w_byte_edge;
  logic             w_data_end;
  logic             w_fcs_end;
  logic             w_crc_en;
  logic             w_crc_init;
  logic             w_crc_bit;

  // One extra bit so len_q+4 never wraps against rdaddress.
  assign w_rdaddr    = {1'b0, rdaddress};
  assign w_len_ext   = {1'b0, r_len};
  assign w_byte_edge = (ShiftCount == 4'd15);
  assign w_data_end  = w_byte_edge && (w_rdaddr == w_len_ext);
  // Dropping on phase 14 lets the final half-bit finish during phase 15.
  assign w_fcs_end   = (ShiftCount == 4'd14) && (w_rdaddr == w_len_ext + FCS_BYTES);

  always_ff @(posedge clk20 or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_gap     <= '0;
      r_sending <= 1'b0;
      r_flush   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_len     <= w_len_nxt;
      r_gap     <= w_gap_nxt;
      r_sending <= w_sending_nxt;
      r_flush   <= w_flush_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_len_nxt     = r_len;
    w_gap_nxt     = r_gap;
    w_sending_nxt = r_sending;
    w_flush_nxt   = r_flush;
    w_done_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && ({1'b0, pkt_len} >= MIN_LEN)) begin
          w_len_nxt     = pkt_len;
          w_sending_nxt = 1'b1;
          w_state_nxt   = DATA;
        end
      end
      DATA: begin
        if (w_data_end) begin
          w_flush_nxt = 1'b1;
          w_state_nxt = FCS;
        end
      end
      FCS: begin
        if (w_fcs_end) begin
          w_sending_nxt = 1'b0;
          w_flush_nxt   = 1'b0;
          w_done_nxt    = 1'b1;
          w_gap_nxt     = GAP_LOAD;
          w_state_nxt   = GAP;
        end
      end
      GAP: begin
        if (r_gap == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_gap_nxt = r_gap - GAP_ONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // One CRC step per wire bit: odd phases, while the frame is active.
  assign w_crc_en   = r_sending && ShiftCount[0];
  assign w_crc_init = (w_rdaddr <= PRE_LAST);

  eth_crc32_serial u_crc (
    .clk     (clk20),
    .rst     (rst),
    .init    (w_crc_init),
    .flush   (r_flush),
    .en      (w_crc_en),
    .din     (ShiftData0),
    .crc_bit (w_crc_bit)
  );

  assign SendingPacket = r_sending;
  assign CRCflush      = r_flush;
  assign CRC           = w_crc_bit;
  assign ready         = (r_state == IDLE);
  assign done          = r_done;

endmodule

// File: tb/tb_eth_tx_frame_sequencer.sv
`timescale 1ns/1ps
module tb_eth_tx_frame_sequencer;

  localparam int LEN_W = 11;
  localparam int PRE   = 8;
  localparam int IPG   = 192;

  logic             clk20 = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] pkt_len;
  logic [3:0]       ShiftCount = 4'd15;
  logic             ShiftData0 = 1'b0;
  logic [LEN_W-1:0] rdaddress  = '0;
  logic             SendingPacket, CRCflush, CRC, ready, done;

  always #25 clk20 = ~clk20;

  eth_tx_frame_sequencer dut (
    .clk20         (clk20),
    .rst           (rst),
    .start         (start),
    .pkt_len       (pkt_len),
    .ShiftCount    (ShiftCount),
    .ShiftData0    (ShiftData0),
    .rdaddress     (rdaddress),
    .SendingPacket (SendingPacket),
    .CRCflush      (CRCflush),
    .CRC           (CRC),
    .ready         (ready),
    .done          (done)
  );

  // ---------------- transmitter model ----------------
  logic [7:0]       ram [0:2047];
  logic [7:0]       tx_sd = 8'd0;
  logic             noise = 1'b0;
  logic [3:0]       sc_n;
  logic [LEN_W-1:0] ra_n;
  logic [7:0]       sd_n;

  always @(posedge clk20) begin
    sc_n = SendingPacket ? ShiftCount + 4'd1 : 4'd15;
    ra_n = rdaddress;
    if (ShiftCount == 4'd15) ra_n = SendingPacket ? rdaddress + 1'b1 : '0;
    sd_n = tx_sd;
    if (ShiftCount[0]) sd_n = (ShiftCount == 4'd15) ? ram[rdaddress] : {1'b0, tx_sd[7:1]};
    #1;
    ShiftCount = sc_n;
    rdaddress  = ra_n;
    tx_sd      = sd_n;
    ShiftData0 = noise ? 1'($urandom) : tx_sd[0];
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          clks;
    int          nbits;
    logic [31:0] fcs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_fcs(input int len);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = PRE; i < len; i++) begin
      c = c ^ {24'd0, ram[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // ---------------- monitor ----------------
  logic        mon_bits[$];
  int          mon_clks = 0;
  logic        last_sp  = 1'b0;
  exp_t        mon_e;
  logic [31:0] mon_fcs;
  logic [31:0] mon_res;
  logic        mon_fb;
  int          mon_n;

  always @(negedge clk20) begin
    if (rst) begin
      mon_bits.delete();
      mon_clks = 0;
    end else begin
      if (SendingPacket) begin
        mon_clks++;
        if (!ShiftCount[0]) mon_bits.push_back(CRCflush ? CRC : ShiftData0);
      end
      if (done) begin
        check("done_after_fall", {31'd0, last_sp && !SendingPacket}, 32'd1);
        check("frame_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          mon_n = mon_bits.size();
          mon_fcs = '0;
          if (mon_n >= 32)
            for (int i = 0; i < 32; i++) mon_fcs[i] = mon_bits[mon_n-32+i];
          mon_res = 32'hFFFFFFFF;
          for (int i = PRE*8; i < mon_n; i++) begin
            mon_fb  = mon_bits[i] ^ mon_res[31];
            mon_res = {mon_res[30:0], 1'b0} ^ ({32{mon_fb}} & 32'h04C11DB7);
          end
          check("sending_clks", mon_clks, mon_e.clks);
          check("wire_bits", mon_n, mon_e.nbits);
          check("fcs", mon_fcs, mon_e.fcs);
          check("rx_residue", mon_res, 32'hC704DD7B);
        end
        mon_bits.delete();
        mon_clks = 0;
      end
    end
    last_sp = SendingPacket;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_exp(input int len, input logic [31:0] fcs);
    exp_t e;
    e.clks  = (len + 4) * 16;
    e.nbits = (len + 4) * 8;
    e.fcs   = fcs;
    exp_q.push_back(e);
  endtask

  task automatic send(input int len, input bit expect_frame, input logic [31:0] fcs);
    @(negedge clk20);
    pkt_len = LEN_W'(len);
    start   = 1'b1;
    if (expect_frame) push_exp(len, fcs);
    @(negedge clk20);
    start = 1'b0;
    check("accepted", {31'd0, SendingPacket}, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 6000) begin
      @(negedge clk20);
      n++;
    end
    check("done_timeout", {31'd0, n < 6000}, 32'd1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 400) begin
      @(negedge clk20);
      n++;
    end
    check("ready_timeout", {31'd0, n < 400}, 32'd1);
  endtask

  task automatic load_payload(input int len);
    for (int i = PRE; i < len; i++) ram[i] = 8'($urandom);
  endtask

  int          low_cnt, rdy0_cnt, bad_a, bad_b, bad_c, guard;
  logic        last_rdy;
  logic [7:0]  kat [0:8];

  initial begin
    rst = 1'b1; start = 1'b0; pkt_len = '0;
    for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
    for (int i = 0; i < 7; i++) ram[i] = 8'h55;
    ram[7] = 8'hD5;

    // reset values, with start held to show rst wins
    repeat (2) @(negedge clk20);
    pkt_len = LEN_W'(17);
    start   = 1'b1;
    repeat (2) @(negedge clk20);
    check("rst_sending", {31'd0, SendingPacket}, 32'd0);
    check("rst_crcflush", {31'd0, CRCflush}, 32'd0);
    check("rst_crc", {31'd0, CRC}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    start = 1'b0;
    @(negedge clk20);
    rst = 1'b0;
    repeat (4) @(negedge clk20);

    // CRC gating in idle with a noisy data bit
    noise = 1'b1; bad_a = 0; bad_b = 0; bad_c = 0;
    repeat (1000) begin
      @(negedge clk20);
      if (dut.u_crc.r_crc !== 32'hFFFFFFFF) bad_a++;
      if (CRCflush !== 1'b0) bad_b++;
      if (SendingPacket !== 1'b0) bad_c++;
    end
    noise = 1'b0;
    check("idle_crc_q_bad_clks", bad_a, 0);
    check("idle_crcflush_bad_clks", bad_b, 0);
    check("idle_sending_bad_clks", bad_c, 0);
    @(negedge clk20);

    // known-answer frame "123456789"; a start during DATA must be ignored
    kat[0] = 8'h31; kat[1] = 8'h32; kat[2] = 8'h33; kat[3] = 8'h34; kat[4] = 8'h35;
    kat[5] = 8'h36; kat[6] = 8'h37; kat[7] = 8'h38; kat[8] = 8'h39;
    for (int i = 0; i < 9; i++) ram[PRE+i] = kat[i];
    send(17, 1'b1, 32'hCBF43926);
    repeat (40) @(negedge clk20);
    pkt_len = LEN_W'(30);
    start   = 1'b1;
    @(negedge clk20);
    start = 1'b0;
    wait_done();
    wait_ready();

    // too-short request (preamble only) is ignored
    repeat (4) @(negedge clk20);
    pkt_len = LEN_W'(8);
    start   = 1'b1;
    @(negedge clk20);
    start = 1'b0;
    bad_a = 0; bad_b = 0; bad_c = 0;
    repeat (40) begin
      @(negedge clk20);
      if (SendingPacket) bad_a++;
      if (done) bad_b++;
      if (!ready) bad_c++;
    end
    check("short_sending_clks", bad_a, 0);
    check("short_done_clks", bad_b, 0);
    check("short_not_ready_clks", bad_c, 0);

    // shortest accepted frame: one covered byte
    ram[PRE] = 8'hA7;
    send(9, 1'b1, ref_fcs(9));
    wait_done();
    wait_ready();

    // minimum Ethernet frame, random payload
    load_payload(68);
    send(68, 1'b1, ref_fcs(68));
    wait_done();
    wait_ready();

    // back-to-back: start held every cycle
    load_payload(20);
    @(negedge clk20);
    pkt_len = LEN_W'(20);
    push_exp(20, ref_fcs(20));
    push_exp(20, ref_fcs(20));
    start = 1'b1;
    guard = 0;
    while (!SendingPacket && guard < 10) begin @(negedge clk20); guard++; end
    while (SendingPacket && guard < 2000) begin @(negedge clk20); guard++; end
    check("b2b_first_frame_timeout", {31'd0, guard < 2000}, 32'd1);
    low_cnt = 0; rdy0_cnt = 0; last_rdy = 1'b0;
    while (!SendingPacket && low_cnt < 400) begin
      low_cnt++;
      if (!ready) rdy0_cnt++;
      last_rdy = ready;
      @(negedge clk20);
    end
    start = 1'b0;
    check("b2b_gap_ge_ipg", {31'd0, low_cnt >= IPG && low_cnt < 400}, 32'd1);
    check("b2b_ready_low_clks", rdy0_cnt, IPG);
    check("b2b_ready_before_restart", {31'd0, last_rdy}, 32'd1);
    wait_done();
    wait_ready();

    // reset during the second FCS byte, then a clean frame
    load_payload(20);
    send(20, 1'b0, 32'd0);
    guard = 0;
    while (!CRCflush && guard < 1000) begin @(negedge clk20); guard++; end
    check("fcs_entry_timeout", {31'd0, guard < 1000}, 32'd1);
    repeat (20) @(negedge clk20);
    rst = 1'b1;
    #1;
    check("abort_sending", {31'd0, SendingPacket}, 32'd0);
    check("abort_crcflush", {31'd0, CRCflush}, 32'd0);
    check("abort_crc", {31'd0, CRC}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd1);
    repeat (2) @(negedge clk20);
    rst = 1'b0;
    repeat (4) @(negedge clk20);
    load_payload(20);
    send(20, 1'b1, ref_fcs(20));
    wait_done();
    wait_ready();

    repeat (4) @(negedge clk20);
    check("frames_outstanding", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
